// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - fetch-stage PC/imem request sequencer with drain path and ack timeout
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_2000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic        pc_en_n_o,
  output logic [31:0] next_pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_i,
  output logic        if_valid_o,
  output logic        flush_o,
  output logic        fetch_fault_o
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  // Counter value seen on the last waiting cycle before the limit is reached
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take_ctl;
  logic             expired;
  logic [31:0]      ctl_target;

  assign take_ctl   = trap_i | redirect_i;
  assign expired    = (cnt_q == CNT_LAST);
  assign ctl_target = trap_i ? {TRAP_VEC[31:2], 2'b00} : {redirect_pc_i[31:2], 2'b00};

  // Next-state, timeout counter and all PC/imem/IF-ID outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    pc_en_n_o     = 1'b1;
    next_pc_o     = pc_i + 32'd4;
    imem_req_o    = 1'b0;
    imem_addr_o   = pc_i;
    if_valid_o    = 1'b0;
    flush_o       = 1'b0;
    fetch_fault_o = 1'b0;
    case (state_q)
      BOOT: begin
        next_pc_o = RESET_PC;
        state_d   = FETCH;
      end
      FETCH: begin
        imem_req_o = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (take_ctl) begin
          // Any same-cycle ack is stale: it belongs to the abandoned path
          pc_en_n_o = 1'b0;
          next_pc_o = ctl_target;
          flush_o   = 1'b1;
          cnt_d     = '0;
          state_d   = imem_ack_i ? FETCH : DRAIN;
        end else if (expired) begin
          pc_en_n_o     = 1'b0;
          next_pc_o     = {TRAP_VEC[31:2], 2'b00};
          flush_o       = 1'b1;
          fetch_fault_o = 1'b1;
          cnt_d         = '0;
          state_d       = imem_ack_i ? FETCH : DRAIN;
        end else if (imem_ack_i) begin
          if_valid_o = 1'b1;
          cnt_d      = '0;
          if (stall_i) begin
            state_d = HOLD;
          end else begin
            pc_en_n_o = 1'b0;
          end
        end
      end
      HOLD: begin
        if (take_ctl) begin
          pc_en_n_o = 1'b0;
          next_pc_o = ctl_target;
          flush_o   = 1'b1;
          state_d   = FETCH;
        end else begin
          if_valid_o = 1'b1;
          if (!stall_i) begin
            pc_en_n_o = 1'b0;
            state_d   = FETCH;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (take_ctl) begin
          pc_en_n_o = 1'b0;
          next_pc_o = ctl_target;
          flush_o   = 1'b1;
        end
        // The stale ack or the silent expiry both end the drain
        if (imem_ack_i || expired) begin
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and timeout counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - scoreboard bench for fetch_seq_ctrl with a modelled PC register
module tb_fetch_seq_ctrl;

  localparam logic [31:0] DC = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_q;
  logic        pc_en_n_o;
  logic [31:0] next_pc_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        trap_i = 1'b0;
  logic        if_valid_o;
  logic        flush_o;
  logic        fetch_fault_o;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        en_n;
    logic [31:0] nxt;
    logic        req;
    logic        v;
    logic        fl;
    logic        ft;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   vec_id = 0;

  always #5 clk = ~clk;

  fetch_seq_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .pc_i          (pc_q),
    .pc_en_n_o     (pc_en_n_o),
    .next_pc_o     (next_pc_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .trap_i        (trap_i),
    .if_valid_o    (if_valid_o),
    .flush_o       (flush_o),
    .fetch_fault_o (fetch_fault_o)
  );

  // PC register the sequencer controls (reset value matches RESET_PC)
  always @(posedge clk or posedge reset) begin
    if (reset) pc_q <= 32'h0000_2000;
    else if (!pc_en_n_o) pc_q <= next_pc_o;
  end

  // Drive one cycle of inputs and queue the hand-computed response
  task automatic step(input logic r, input logic a, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic tr,
                      input logic [31:0] e_pc, input logic e_en_n, input logic [31:0] e_nxt,
                      input logic e_req, input logic e_v, input logic e_fl, input logic e_ft);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; imem_ack_i = a; stall_i = st; redirect_i = rd; redirect_pc_i = rpc; trap_i = tr;
    e.id = vec_id; e.pc = e_pc; e.en_n = e_en_n; e.nxt = e_nxt;
    e.req = e_req; e.v = e_v; e.fl = e_fl; e.ft = e_ft;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation mid-cycle
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        bad = (pc_q !== e.pc) || (pc_en_n_o !== e.en_n) || (imem_req_o !== e.req) ||
              (if_valid_o !== e.v) || (flush_o !== e.fl) || (fetch_fault_o !== e.ft) ||
              (e.req && (imem_addr_o !== e.pc)) || ((e.nxt != DC) && (next_pc_o !== e.nxt));
        compared++;
        if (bad) begin
          mismatched++;
          $display("FAIL vec%0d: got pc=%h en_n=%b next=%h req=%b addr=%h v=%b fl=%b ft=%b, want pc=%h en_n=%b next=%h req=%b v=%b fl=%b ft=%b",
                   e.id, pc_q, pc_en_n_o, next_pc_o, imem_req_o, imem_addr_o, if_valid_o, flush_o,
                   fetch_fault_o, e.pc, e.en_n, e.nxt, e.req, e.v, e.fl, e.ft);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    //   r  a  st rd rpc           tr  pc            en nxt           rq v  fl ft
    step(1, 0, 0, 0, 32'h0,        0,  32'h0000_2000, 1, 32'h0000_2000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0,  32'h0000_2000, 1, 32'h0000_2000, 0, 0, 0, 0);
    // sequential fetch
    step(0, 1, 0, 0, 32'h0,        0,  32'h0000_2000, 0, 32'h0000_2004, 1, 1, 0, 0);
    step(0, 1, 0, 0, 32'h0,        0,  32'h0000_2004, 0, 32'h0000_2008, 1, 1, 0, 0);
    // ack under stall, three hold cycles, release
    step(0, 1, 1, 0, 32'h0,        0,  32'h0000_2008, 1, DC,            1, 1, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0,  32'h0000_2008, 1, DC,            0, 1, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0,  32'h0000_2008, 1, DC,            0, 1, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0,  32'h0000_2008, 1, DC,            0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0,  32'h0000_2008, 0, 32'h0000_200C, 0, 1, 0, 0);
    // redirect with a request outstanding, stale ack in drain
    step(0, 0, 0, 0, 32'h0,        0,  32'h0000_200C, 1, DC,            1, 0, 0, 0);
    step(0, 0, 0, 1, 32'h3003,     0,  32'h0000_200C, 0, 32'h0000_3000, 1, 0, 1, 0);
    step(0, 0, 0, 0, 32'h0,        0,  32'h0000_3000, 1, DC,            0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0,        0,  32'h0000_3000, 1, DC,            0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0,        0,  32'h0000_3000, 0, 32'h0000_3004, 1, 1, 0, 0);
    // trap + redirect + ack together: trap wins, ack discarded
    step(0, 1, 0, 1, 32'h5000,     1,  32'h0000_3004, 0, 32'h0000_0100, 1, 0, 1, 0);
    // redirect overrides a stalled ack
    step(0, 1, 1, 1, 32'h4000,     0,  32'h0000_0100, 0, 32'h0000_4000, 1, 0, 1, 0);
    // ack timeout: 15 quiet waiting cycles, fault on the 16th
    for (int i = 0; i < 15; i++)
      step(0, 0, 0, 0, 32'h0,      0,  32'h0000_4000, 1, DC,            1, 0, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0,  32'h0000_4000, 0, 32'h0000_0100, 1, 0, 1, 1);
    step(0, 0, 0, 0, 32'h0,        0,  32'h0000_0100, 1, DC,            0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0,        0,  32'h0000_0100, 1, DC,            0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0,        0,  32'h0000_0100, 0, 32'h0000_0104, 1, 1, 0, 0);
    // redirect into drain, then redirect while draining stays in drain
    step(0, 0, 0, 1, 32'h0602,     0,  32'h0000_0104, 0, 32'h0000_0600, 1, 0, 1, 0);
    step(0, 0, 0, 1, 32'h07FC,     0,  32'h0000_0600, 0, 32'h0000_07FC, 0, 0, 1, 0);
    step(0, 1, 0, 0, 32'h0,        0,  32'h0000_07FC, 1, DC,            0, 0, 0, 0);
    // drain with no ack expires silently
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0000_07FC, 0, 32'hFFFF_FFFC, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++)
      step(0, 0, 0, 0, 32'h0,      0,  32'hFFFF_FFFC, 1, DC,            0, 0, 0, 0);
    // PC wrap
    step(0, 1, 0, 0, 32'h0,        0,  32'hFFFF_FFFC, 0, 32'h0000_0000, 1, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0,  32'h0000_0000, 1, DC,            1, 0, 0, 0);
    // asynchronous reset mid-fetch; acks ignored until fetch resumes
    step(1, 0, 0, 0, 32'h0,        0,  32'h0000_2000, 1, 32'h0000_2000, 0, 0, 0, 0);
    step(1, 1, 0, 0, 32'h0,        0,  32'h0000_2000, 1, 32'h0000_2000, 0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0,        0,  32'h0000_2000, 1, 32'h0000_2000, 0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0,        0,  32'h0000_2000, 0, 32'h0000_2004, 1, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0,        0,  32'h0000_2004, 1, DC,            1, 0, 0, 0);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
